keyboard_ring_ctrl: RTL and testbench

- Circular-buffer controller that sequences a 32-word x 32-bit byte-write dual-port keyboard RAM (128 scancode bytes) as a FIFO.
- Packs PS/2 scancodes into the RAM write port and prefetches the oldest byte through the RAM read port.
- Exposes STATUS and DATA MMIO registers to the CPU in the 0x3xxxx region; a CPU read of DATA pops one byte.
- Sits between ps2_rx, the RAM instance and the CPU memory-mapped bus.

---
 rtl/keyboard_ring_ctrl_if.sv | 26 ++
 rtl/keyboard_ring_ctrl.sv | 99 +++++++++
 tb/tb_keyboard_ring_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/keyboard_ring_ctrl_if.sv
// keyboard_ring_ctrl_if: scancode, CPU MMIO and keyboard RAM signals of the ring controller.
interface keyboard_ring_ctrl_if;
   logic [7:0]  kb_scancode_in;
   logic        kb_valid_in;
   logic [31:0] cpu_addr_in;
   logic [3:0]  cpu_write_enable_in;
   logic [31:0] cpu_wdata_in;
   logic        cpu_read_in;
   logic [31:0] cpu_data_out;
   logic        irq_out;
   logic [4:0]  ram_waddr_out;
   logic [31:0] ram_wdata_out;
   logic [3:0]  ram_we_out;
   logic [4:0]  ram_raddr_out;
   logic [31:0] ram_rdata_in;
   modport slave (
      input  kb_scancode_in, kb_valid_in, cpu_addr_in, cpu_write_enable_in, cpu_wdata_in,
             cpu_read_in, ram_rdata_in,
      output cpu_data_out, irq_out, ram_waddr_out, ram_wdata_out, ram_we_out, ram_raddr_out
   );
   modport master (
      output kb_scancode_in, kb_valid_in, cpu_addr_in, cpu_write_enable_in, cpu_wdata_in,
             cpu_read_in, ram_rdata_in,
      input  cpu_data_out, irq_out, ram_waddr_out, ram_wdata_out, ram_we_out, ram_raddr_out
   );
endinterface

// File: rtl/keyboard_ring_ctrl.sv
// keyboard_ring_ctrl: 128-byte scancode FIFO held in a 32x32 byte-write RAM,
// with a one-byte prefetch of the oldest entry and STATUS/DATA MMIO registers.
module keyboard_ring_ctrl #(
   parameter logic [3:0]  REGION      = 4'h3,
   parameter logic [19:0] STATUS_ADDR = 20'h30080,
   parameter logic [19:0] DATA_ADDR   = 20'h30084,
   parameter int          RAM_LATENCY = 2
) (
   input logic                 clk_in,
   input logic                 rst_in,
   keyboard_ring_ctrl_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
   state_t     state_q, state_d;
   logic [6:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0] count_q, count_d, head_byte_q, head_byte_d;
   logic [3:0] lat_q, lat_d;
   logic       head_valid_q, head_valid_d, overflow_q, overflow_d, irq_en_q, irq_en_d, irq_q;
   logic       sel_status, sel_data, flush, full, push_acc, pop, stall, unused_ok;
   assign sel_status = bus.cpu_addr_in[19:16] == REGION && bus.cpu_addr_in[19:0] == STATUS_ADDR;
   assign sel_data   = bus.cpu_addr_in[19:16] == REGION && bus.cpu_addr_in[19:0] == DATA_ADDR;
   assign flush      = sel_status && bus.cpu_write_enable_in[3] && bus.cpu_wdata_in[31];
   assign full       = count_q == 8'd128;
   assign push_acc   = bus.kb_valid_in && !full && !flush;
   assign pop        = sel_data && bus.cpu_read_in && head_valid_q && !flush;
   // A same-cycle write into the word being read would race the RAM read port.
   assign stall      = push_acc && wr_ptr_q[6:2] == rd_ptr_q[6:2];
   assign unused_ok  = ^{bus.cpu_addr_in[31:20], bus.cpu_wdata_in[30:17], bus.cpu_wdata_in[15:2],
                         bus.cpu_wdata_in[0], bus.cpu_write_enable_in[1]};
   assign bus.ram_waddr_out = wr_ptr_q[6:2];
   assign bus.ram_we_out    = push_acc ? 4'b0001 << wr_ptr_q[1:0] : 4'b0000;
   assign bus.ram_wdata_out = {4{bus.kb_scancode_in}};
   assign bus.ram_raddr_out = rd_ptr_q[6:2];
   assign bus.irq_out       = irq_q;
   assign bus.cpu_data_out  = sel_status ? {15'b0, irq_en_q, count_q, 6'b0, overflow_q, count_q != 8'd0} :
                              sel_data   ? {23'b0, head_valid_q, head_byte_q} : 32'b0;
   always_comb begin
      state_d      = state_q;
      lat_d        = lat_q;
      head_byte_d  = head_byte_q;
      head_valid_d = head_valid_q && !pop;
      wr_ptr_d     = wr_ptr_q + 7'(push_acc);
      rd_ptr_d     = rd_ptr_q + 7'(pop);
      count_d      = count_q + 8'(push_acc) - 8'(pop);
      overflow_d   = (overflow_q && !(sel_status && bus.cpu_write_enable_in[0] && bus.cpu_wdata_in[1]))
                     || (bus.kb_valid_in && full);
      irq_en_d     = sel_status && bus.cpu_write_enable_in[2] ? bus.cpu_wdata_in[16] : irq_en_q;
      // The ISSUE cycle is the first of the RAM_LATENCY cycles; capture lands on the last WAIT cycle.
      case (state_q)
         S_IDLE:  state_d = !head_valid_q && count_q != 8'd0 ? S_ISSUE : S_IDLE;
         S_ISSUE: begin
            state_d = stall ? S_ISSUE : S_WAIT;
            lat_d   = 4'd1;
         end
         S_WAIT: begin
            lat_d = lat_q + 4'd1;
            if (lat_q >= 4'(RAM_LATENCY - 1)) begin
               head_byte_d  = bus.ram_rdata_in[{rd_ptr_q[1:0], 3'b000} +: 8];
               head_valid_d = 1'b1;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         wr_ptr_d     = 7'd0;
         rd_ptr_d     = 7'd0;
         count_d      = 8'd0;
         head_valid_d = 1'b0;
         state_d      = S_IDLE;
         lat_d        = 4'd0;
      end
   end
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q      <= S_IDLE;
         lat_q        <= 4'd0;
         wr_ptr_q     <= 7'd0;
         rd_ptr_q     <= 7'd0;
         count_q      <= 8'd0;
         head_byte_q  <= 8'd0;
         head_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         irq_en_q     <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         lat_q        <= lat_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         head_byte_q  <= head_byte_d;
         head_valid_q <= head_valid_d;
         overflow_q   <= overflow_d;
         irq_en_q     <= irq_en_d;
         irq_q        <= irq_en_q && count_q != 8'd0;
      end
   end
endmodule

// File: tb/tb_keyboard_ring_ctrl.sv
// tb_keyboard_ring_ctrl: random and directed stimulus against a queue-based FIFO model,
// with a registered-read RAM attached to the controller.
module tb_keyboard_ring_ctrl;
   localparam logic [31:0] ST = 32'h0003_0080;
   localparam logic [31:0] DA = 32'h0003_0084;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [31:0] mem [32];
   logic [7:0] q [$];
   logic       ov = 1'b0, ien = 1'b0, irq_exp = 1'b0;
   int         pushed = 0, n_chk = 0, n_pass = 0;
   keyboard_ring_ctrl_if bus ();
   keyboard_ring_ctrl dut (.clk_in(clk), .rst_in(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (bus.ram_we_out[i]) mem[bus.ram_waddr_out][8*i +: 8] <= bus.ram_wdata_out[8*i +: 8];
      bus.ram_rdata_in <= mem[bus.ram_raddr_out];
   end
   initial begin
      #5_000_000;
      $display("FAIL watchdog: run did not finish, required finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h, want %h", tag, obs, exp);
   endtask
   task automatic cyc(input logic kv, input logic [7:0] sc, input logic [31:0] addr, input logic [3:0] we,
                      input logic [31:0] wd, input logic rd, output logic [31:0] dout);
      logic st, dt, fl, popped;
      int n;
      bus.kb_valid_in = kv;
      bus.kb_scancode_in = sc;
      bus.cpu_addr_in = addr;
      bus.cpu_write_enable_in = we;
      bus.cpu_wdata_in = wd;
      bus.cpu_read_in = rd;
      #1;
      dout = bus.cpu_data_out;
      n = q.size();
      st = addr[19:0] == ST[19:0];
      dt = addr[19:0] == DA[19:0];
      fl = st && we[3] && wd[31];
      check("irq", 32'(bus.irq_out), 32'(irq_exp));
      if (st && we == 4'b0) check("status", dout, {15'b0, ien, 8'(n), 6'b0, ov, n != 0});
      if (!st && !dt) check("other_addr", dout, 32'b0);
      if (dt) begin
         check("data_hi", 32'(dout[31:9]), 32'b0);
         if (n == 0) check("data_hv_empty", 32'(dout[8]), 32'b0);
         else if (dout[8]) check("data_byte", 32'(dout[7:0]), 32'(q[0]));
      end
      if (kv && n < 128 && !fl) begin
         check("ram_w", 32'({bus.ram_waddr_out, bus.ram_we_out}),
               32'({5'((pushed / 4) % 32), 4'(1 << (pushed % 4))}));
         check("ram_wd", bus.ram_wdata_out, {4{sc}});
      end else check("ram_we0", 32'(bus.ram_we_out), 32'b0);
      popped = rd && dt && dout[8] && n > 0 && !fl;
      irq_exp = ien && n != 0;
      if (st && we[0] && wd[1]) ov = 1'b0;
      if (kv && n == 128) ov = 1'b1;
      if (st && we[2]) ien = wd[16];
      if (fl) begin
         q.delete();
         pushed = 0;
      end else begin
         if (popped) void'(q.pop_front());
         if (kv && n < 128) begin
            q.push_back(sc);
            pushed++;
         end
      end
      @(negedge clk);
   endtask
   task automatic wait_head();
      logic [31:0] d;
      int k = 0;
      d = 32'b0;
      while (!d[8] && k < 20) begin
         cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
         k++;
      end
      check("head_timeout", 32'(d[8]), 32'd1);
   endtask
   task automatic drain();
      logic [31:0] d;
      int guard = 0;
      while (q.size() > 0 && guard < 2000) begin
         cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b1, d);
         guard++;
      end
      check("drain", 32'(q.size()), 32'd0);
   endtask
   initial begin
      logic [31:0] d;
      logic [7:0] seq [5];
      int r;
      seq = '{8'h1C, 8'hF0, 8'h1C, 8'h29, 8'h5A};
      bus.kb_valid_in = 1'b0;
      bus.kb_scancode_in = 8'h0;
      bus.cpu_addr_in = 32'b0;
      bus.cpu_write_enable_in = 4'b0;
      bus.cpu_wdata_in = 32'b0;
      bus.cpu_read_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_irq", 32'(bus.irq_out), 32'b0);
      check("rst_we", 32'(bus.ram_we_out), 32'b0);
      check("rst_waddr", 32'(bus.ram_waddr_out), 32'b0);
      check("rst_raddr", 32'(bus.ram_raddr_out), 32'b0);
      rst_n = 1'b1;
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b1, d);
      check("empty_pop", d, 32'h000);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("empty_pop_status", d, 32'h0);
      cyc(1'b1, 8'h1C, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      check("lat_cycle3", d, 32'h000);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b1, d);
      check("lat_cycle4", d, 32'h11C);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("after_pop_status", d, 32'h0);
      cyc(1'b0, 8'h0, ST, 4'b1000, 32'h8000_0000, 1'b0, d);
      for (int i = 0; i < 5; i++) cyc(1'b1, seq[i], DA, 4'b0, 32'b0, 1'b0, d);
      drain();
      for (int i = 0; i < 129; i++) cyc(1'b1, 8'($urandom), 32'h0, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("full_status", d, 32'h0000_8003);
      cyc(1'b0, 8'h0, ST, 4'b0001, 32'h2, 1'b0, d);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("ov_cleared", d, 32'h0000_8001);
      drain();
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), DA, 4'b0, 32'b0, 1'b0, d);
      wait_head();
      cyc(1'b1, 8'hAA, DA, 4'b0, 32'b0, 1'b1, d);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("pop_push_count", d, 32'h0000_0501);
      drain();
      cyc(1'b1, 8'h33, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, ST, 4'b1000, 32'h8000_0000, 1'b0, d);
      repeat (4) cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      check("flush_hv", 32'(d[8]), 32'b0);
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("flush_status", d, 32'h0);
      cyc(1'b0, 8'h0, ST, 4'b0100, 32'h0001_0000, 1'b0, d);
      cyc(1'b1, 8'h45, DA, 4'b0, 32'b0, 1'b0, d);
      repeat (3) cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      check("irq_high", 32'(bus.irq_out), 32'd1);
      drain();
      repeat (2) cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      check("irq_low", 32'(bus.irq_out), 32'b0);
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40) cyc(1'($urandom), 8'($urandom), DA, 4'b0, 32'b0, 1'b1, d);
         else if (r < 55) cyc(1'($urandom), 8'($urandom), DA, 4'b0, 32'b0, 1'b0, d);
         else if (r < 70) cyc(1'($urandom), 8'($urandom), ST, 4'b0, 32'b0, 1'b0, d);
         else if (r < 72) cyc(1'($urandom), 8'($urandom), ST, 4'b1000, 32'h8000_0000, 1'b0, d);
         else if (r < 74) cyc(1'($urandom), 8'($urandom), ST, 4'b0001, 32'h2, 1'b0, d);
         else if (r < 77) cyc(1'($urandom), 8'($urandom), ST, 4'b0100, {15'b0, 1'($urandom), 16'b0}, 1'b0, d);
         else if (r < 88) cyc(1'($urandom), 8'($urandom), 32'h0003_0088, 4'b0, 32'b0, 1'b1, d);
         else cyc(1'($urandom), 8'($urandom), 32'h0002_0084, 4'b0, 32'b0, 1'b1, d);
      end
      drain();
      cyc(1'b0, 8'h0, ST, 4'b0100, 32'h0001_0000, 1'b0, d);
      cyc(1'b1, 8'h77, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      cyc(1'b0, 8'h0, DA, 4'b0, 32'b0, 1'b0, d);
      bus.kb_valid_in = 1'b0;
      bus.cpu_addr_in = ST;
      bus.cpu_write_enable_in = 4'b0;
      bus.cpu_read_in = 1'b0;
      rst_n = 1'b0;
      #1;
      check("arst_irq", 32'(bus.irq_out), 32'b0);
      check("arst_we", 32'(bus.ram_we_out), 32'b0);
      check("arst_waddr", 32'(bus.ram_waddr_out), 32'b0);
      check("arst_raddr", 32'(bus.ram_raddr_out), 32'b0);
      check("arst_status", bus.cpu_data_out, 32'b0);
      q.delete();
      pushed = 0;
      ov = 1'b0;
      ien = 1'b0;
      irq_exp = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b0, 8'h0, ST, 4'b0, 32'b0, 1'b0, d);
      check("post_rst_status", d, 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
